// File: rtl/lut_mult_pkg.sv
// Shared parameters, payload types and arithmetic helpers for the LUT constant multiplier.
// Optional feature macro: LUT_MULT_SAT_EN (clamp results and flag overflow instead of wrapping).
package lut_mult_pkg;

    localparam int unsigned IN_W    = 32;
    localparam int unsigned CONST_W = 28;
    localparam int unsigned FRAC    = 15;
    localparam int unsigned OUT_W   = 32;
    localparam int unsigned LANES   = 3;
    localparam int unsigned NROWS   = 8;
    localparam int unsigned STAGES  = 3;

    localparam int unsigned PROD_W  = IN_W + CONST_W;
    localparam int unsigned SEL_W   = $clog2(NROWS);
    localparam int unsigned ADDR_W  = $clog2(NROWS * LANES);

    // Coefficient value 1.0 in Q(CONST_W-FRAC).FRAC
    localparam logic [CONST_W-1:0] ONE = CONST_W'(1) << FRAC;

    // Half an output LSB, added before the arithmetic shift for round-half-up
    localparam logic signed [PROD_W-1:0] HALF = PROD_W'(1) <<< (FRAC - 1);

    // Final-stage lane result plus its clamp indication
    typedef struct packed {
        logic             clamp;
        logic [OUT_W-1:0] data;
    } lane_res_t;

    // Round half up and drop the fractional bits
    function automatic logic signed [PROD_W-1:0] round_shift(input logic signed [PROD_W-1:0] p);
        return (p + HALF) >>> FRAC;
    endfunction

    // Narrow a rounded product to OUT_W, either saturating or wrapping
    function automatic lane_res_t sat_or_wrap(input logic signed [PROD_W-1:0] r);
        lane_res_t res;
        res.clamp = 1'b0;
        res.data  = OUT_W'(r);
`ifdef LUT_MULT_SAT_EN
        // Upper bits not a pure sign extension means the value does not fit OUT_W
        if (!(&r[PROD_W-1:OUT_W-1]) && (|r[PROD_W-1:OUT_W-1])) begin
            res.clamp = 1'b1;
            res.data  = r[PROD_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
`endif
        return res;
    endfunction

endpackage

// File: rtl/lut_mult_lane.sv
// One lane of the multiplier: capture, multiply, retime, round and narrow.
// All registers move on the shared advance enable; validity is tracked by the parent.
module lut_mult_lane
    import lut_mult_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               advance,
    input  logic [IN_W-1:0]    sample,
    input  logic [CONST_W-1:0] coef,
    output logic [OUT_W-1:0]   res,
    output logic               clamp_c
);

    logic signed [IN_W-1:0]    sample_q;
    logic signed [CONST_W-1:0] coef_q;
    logic signed [PROD_W-1:0]  prod_c;
    logic signed [PROD_W-1:0]  last_c;
    lane_res_t                 fin_c;

    // Stage 0: capture the sample and its coefficient
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q <= '0;
            coef_q   <= '0;
        end else if (advance) begin
            sample_q <= sample;
            coef_q   <= coef;
        end
    end

    assign prod_c = PROD_W'(sample_q) * PROD_W'(coef_q);

    generate
        if (STAGES == 2) begin : g_direct
            assign last_c = prod_c;
        end else begin : g_retime
            logic signed [PROD_W-1:0] prod_q [STAGES-2];

            // Stage 1 registers the full product; later stages only retime it
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < int'(STAGES) - 2; i++) prod_q[i] <= '0;
                end else if (advance) begin
                    prod_q[0] <= prod_c;
                    for (int i = 1; i < int'(STAGES) - 2; i++) prod_q[i] <= prod_q[i-1];
                end
            end

            assign last_c = prod_q[STAGES-3];
        end
    endgenerate

    assign fin_c   = sat_or_wrap(round_shift(last_c));
    assign clamp_c = fin_c.clamp;

    // Last stage: registered rounded/narrowed result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res <= '0;
        end else if (advance) begin
            res <= fin_c.data;
        end
    end

endmodule

// File: rtl/lut_mult_pipe.sv
// Multi-lane pipelined signed fixed-point constant multiplier with loadable coefficient bank.
// Global-stall pipeline: every stage shifts together when the output is free or being taken.
// Optional feature macro: LUT_MULT_SAT_EN (saturate results and raise sticky ovf).
module lut_mult_pipe
    import lut_mult_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    input  logic                   cfg_we,
    input  logic [ADDR_W-1:0]      cfg_addr,
    input  logic [CONST_W-1:0]     cfg_data,
    output logic                   ovf
);

    logic                advance;
    logic [STAGES-1:0]   vld;
    logic [CONST_W-1:0]  bank [NROWS][LANES];
    logic [SEL_W-1:0]    row_c;
    logic [LANES-1:0]    clamp_c;

    assign advance   = !vld[STAGES-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld[STAGES-1];

    // Out-of-range row selects fall back to row 0
    assign row_c = ({1'b0, in_sel} < (SEL_W+1)'(NROWS)) ? in_sel : '0;

    // Valid chain; bubbles travel as invalid stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else if (advance) begin
            vld <= {vld[STAGES-2:0], in_valid};
        end
    end

    // Coefficient bank; a write lands after the same-cycle read by stage 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < int'(NROWS); r++)
                for (int l = 0; l < int'(LANES); l++)
                    bank[r][l] <= ONE;
        end else begin
            for (int r = 0; r < int'(NROWS); r++)
                for (int l = 0; l < int'(LANES); l++)
                    if (cfg_we && (cfg_addr == ADDR_W'(r * int'(LANES) + l)))
                        bank[r][l] <= cfg_data;
        end
    end

    // Sticky overflow, set as a clamped valid beat enters the output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (advance && vld[STAGES-2] && (|clamp_c)) begin
            ovf <= 1'b1;
        end
    end

    generate
        for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
            lut_mult_lane u_lane (
                .clk     (clk),
                .rst     (rst),
                .advance (advance),
                .sample  (in_data[l*IN_W +: IN_W]),
                .coef    (bank[row_c][l]),
                .res     (out_data[l*OUT_W +: OUT_W]),
                .clamp_c (clamp_c[l])
            );
        end
    endgenerate

endmodule
